// File: rtl/network_mac_pkg.sv
// network_mac_pkg: shared constants, rescaling helper and parameter checks for network_mac_pipe
package network_mac_pkg;
  typedef struct packed {
    logic signed [63:0] val;
    logic               clip;
  } rs_t;
  function automatic int latency(input int mul_stages);
    return mul_stages + 1;
  endfunction
  function automatic bit params_ok(input int a_w, input int b_w, input int mul_stages,
                                   input int acc_w, input int shift, input int out_w);
    return a_w > 0 && b_w > 0 && mul_stages >= 1 && acc_w >= a_w + b_w && acc_w <= 126 &&
           shift >= 0 && shift < acc_w && out_w > 1 && out_w <= 64;
  endfunction
  function automatic rs_t round_sat(input logic signed [127:0] v, input int shift, input int out_w);
    logic signed [127:0] r, hi, lo;
    rs_t res;
    r = (v + (shift > 0 ? (128'sd1 <<< (shift - 1)) : 128'sd0)) >>> shift;
    hi = (128'sd1 <<< (out_w - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (out_w - 1));
    res.clip = r > hi || r < lo;
    res.val = 64'(r > hi ? hi : r < lo ? lo : r);
    return res;
  endfunction
endpackage

// File: rtl/network_mac_mul_pipe.sv
// network_mac_mul_pipe: signed multiplier (input register + STAGES product registers, ce-gated) with valid/last sideband; ports clk, reset(active-low sync), ce, in_valid, in_last, din0, din1 -> out_valid, out_last, prod
module network_mac_mul_pipe #(
  parameter int A_W = 16,
  parameter int B_W = 13,
  parameter int STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic [A_W-1:0]       din0,
  input  logic [B_W-1:0]       din1,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [A_W+B_W-1:0]   prod
);
  logic [A_W-1:0] a_r;
  logic [B_W-1:0] b_r;
  logic signed [A_W+B_W-1:0] p [STAGES];
  logic [STAGES:0] v, l;
  always_ff @(posedge clk) begin
    if (ce) begin
      a_r <= din0;
      b_r <= din1;
      p[0] <= $signed(a_r) * $signed(b_r);
      for (int i = 1; i < STAGES; i++) p[i] <= p[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      v <= '0;
      l <= '0;
    end else if (ce) begin
      v <= {v[STAGES-1:0], in_valid};
      l <= {l[STAGES-1:0], in_last};
    end
  end
  assign out_valid = v[STAGES];
  assign out_last  = l[STAGES];
  assign prod      = p[STAGES-1];
endmodule

// File: rtl/network_mac_pipe.sv
// network_mac_pipe: signed MAC with group framing, round-half-up rescale and saturation; ports clk, reset(active-low sync), ce, in_valid, din0, din1, in_last -> out_valid, dout, out_sat
module network_mac_pipe
  import network_mac_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = 13,
  parameter int MUL_STAGES = 2,
  parameter int ACC_W = 40,
  parameter int SHIFT = 12,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [A_W-1:0]   din0,
  input  logic [B_W-1:0]   din1,
  input  logic             in_last,
  output logic             out_valid,
  output logic [OUT_W-1:0] dout,
  output logic             out_sat
);
  if (!params_ok(A_W, B_W, MUL_STAGES, ACC_W, SHIFT, OUT_W)) begin : g_bad_params
    $error("network_mac_pipe: illegal parameter combination");
  end
  logic pv, pl, first, ovf, ovf_add, ovf_n;
  logic [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0] acc, base, pe, sum;
  rs_t rs;
  network_mac_mul_pipe #(.A_W(A_W), .B_W(B_W), .STAGES(MUL_STAGES)) u_mul (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_last(in_last),
    .din0(din0), .din1(din1), .out_valid(pv), .out_last(pl), .prod(prod)
  );
  always_comb begin
    pe      = ACC_W'($signed(prod));
    base    = first ? '0 : acc;
    sum     = base + pe;
    ovf_add = (base[ACC_W-1] == pe[ACC_W-1]) && (sum[ACC_W-1] != base[ACC_W-1]);
    ovf_n   = (first ? 1'b0 : ovf) | ovf_add;
    rs      = round_sat(128'(sum), SHIFT, OUT_W);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc       <= '0;
      ovf       <= 1'b0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      dout      <= '0;
      out_sat   <= 1'b0;
    end else if (ce) begin
      out_valid <= pv && pl;
      if (pv) begin
        acc   <= sum;
        ovf   <= ovf_n;
        first <= pl;
        if (pl) begin
          dout    <= OUT_W'(rs.val);
          out_sat <= rs.clip | ovf_n;
        end
      end
    end
  end
endmodule
